// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: bundle of the two client request/response channels and the
// byte-wide RAM/IO port. The controller uses the slave view, the surrounding
// system (clients, RAM, UART status) uses the master view.
interface mem_ctrl_if;
   logic        rdy;
   logic        ic_ena;
   logic [31:0] ic_addr;
   logic        ic_valid;
   logic [31:0] ic_data;
   logic        ls_ena;
   logic        ls_wr;
   logic [1:0]  ls_size;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_valid;
   logic [31:0] ls_rdata;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;

   modport slave (
      input  rdy, ic_ena, ic_addr, ls_ena, ls_wr, ls_size, ls_addr, ls_wdata,
             mem_din, io_buffer_full,
      output ic_valid, ic_data, ls_valid, ls_rdata, mem_dout, mem_a, mem_wr
   );

   modport master (
      output rdy, ic_ena, ic_addr, ls_ena, ls_wr, ls_size, ls_addr, ls_wdata,
             mem_din, io_buffer_full,
      input  ic_valid, ic_data, ls_valid, ls_rdata, mem_dout, mem_a, mem_wr
   );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: round-robin arbiter between icache and load/store buffer that
// serializes 1/2/4-byte accesses onto a byte-wide RAM/IO port. Read bytes are
// assembled little-endian; I/O stores stall while the UART buffer is full.
module mem_ctrl (
   input  logic      clk,
   input  logic      rst,
   mem_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;

   localparam logic CLIENT_IC = 1'b0;
   localparam logic CLIENT_LS = 1'b1;

   state_t      state_reg, state_next;
   logic [2:0]  cnt_reg, cnt_next;       // READ: edge index since accept; WRITE: next byte
   logic [2:0]  len_reg, len_next;       // byte count 1/2/4
   logic [31:0] base_reg, base_next;
   logic [31:0] wdata_reg, wdata_next;
   logic        client_reg, client_next;
   logic        last_reg, last_next;     // client granted most recently
   logic [31:0] buf_reg, buf_next;       // partially assembled read data
   logic [31:0] mem_a_reg, mem_a_next;
   logic [7:0]  mem_dout_reg, mem_dout_next;
   logic        mem_wr_reg, mem_wr_next;
   logic        ic_valid_reg, ic_valid_next;
   logic        ls_valid_reg, ls_valid_next;
   logic [31:0] ic_data_reg, ic_data_next;
   logic [31:0] ls_rdata_reg, ls_rdata_next;

   logic [2:0]  ls_len;
   logic        grant_ls;
   logic        stall_accept;
   logic        stall_write;
   logic [31:0] issue_addr;
   logic [31:0] capture_word;
   logic [31:0] final_word;
   logic [7:0]  wbyte [4];

   // Decode the LSB access size into a byte count; size 3 behaves as a word.
   always_comb begin
      ls_len = 3'd4;
      case (bus.ls_size)
         2'd0:    ls_len = 3'd1;
         2'd1:    ls_len = 3'd2;
         default: ls_len = 3'd4;
      endcase
   end

   // On a tie the client that did not win last time gets the port.
   assign grant_ls     = bus.ls_ena && (!bus.ic_ena || (last_reg == CLIENT_IC));
   assign stall_accept = bus.io_buffer_full && (bus.ls_addr[17:16] == 2'b11);
   assign stall_write  = bus.io_buffer_full && (base_reg[17:16] == 2'b11);
   assign issue_addr   = base_reg + {29'd0, cnt_reg};

   // Per-byte-lane views: the lane captured this edge (RAM has one cycle of
   // latency, so byte i arrives two edges after its issue), the lane that
   // completes the word on the final edge, and the store data bytes.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [2:0] CAP_CNT  = 3'(gi + 2);
         localparam logic [2:0] LAST_LEN = 3'(gi + 1);
         assign capture_word[8*gi +: 8] = (cnt_reg == CAP_CNT)  ? bus.mem_din : buf_reg[8*gi +: 8];
         assign final_word[8*gi +: 8]   = (len_reg == LAST_LEN) ? bus.mem_din : buf_reg[8*gi +: 8];
         assign wbyte[gi]               = wdata_reg[8*gi +: 8];
      end
   endgenerate

   // Next-state and output logic; valid pulses and mem_wr default low so they
   // last only for the edge that produces them.
   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      len_next      = len_reg;
      base_next     = base_reg;
      wdata_next    = wdata_reg;
      client_next   = client_reg;
      last_next     = last_reg;
      buf_next      = buf_reg;
      mem_a_next    = mem_a_reg;
      mem_dout_next = mem_dout_reg;
      mem_wr_next   = 1'b0;
      ic_valid_next = 1'b0;
      ls_valid_next = 1'b0;
      ic_data_next  = ic_data_reg;
      ls_rdata_next = ls_rdata_reg;

      case (state_reg)
         IDLE: begin
            // Wait out the valid cycle so the client can change its address.
            if (!ic_valid_reg && !ls_valid_reg && (bus.ic_ena || bus.ls_ena)) begin
               buf_next = '0;
               cnt_next = 3'd1;
               if (grant_ls) begin
                  client_next = CLIENT_LS;
                  last_next   = CLIENT_LS;
                  base_next   = bus.ls_addr;
                  len_next    = ls_len;
                  wdata_next  = bus.ls_wdata;
                  if (bus.ls_wr) begin
                     state_next = WRITE;
                     if (stall_accept) begin
                        cnt_next = 3'd0;
                     end else begin
                        mem_a_next    = bus.ls_addr;
                        mem_dout_next = bus.ls_wdata[7:0];
                        mem_wr_next   = 1'b1;
                     end
                  end else begin
                     state_next = READ;
                     mem_a_next = bus.ls_addr;
                  end
               end else begin
                  client_next = CLIENT_IC;
                  last_next   = CLIENT_IC;
                  base_next   = bus.ic_addr;
                  len_next    = 3'd4;
                  state_next  = READ;
                  mem_a_next  = bus.ic_addr;
               end
            end
         end
         READ: begin
            if ((client_reg == CLIENT_IC) && !bus.ic_ena) begin
               state_next = IDLE;
               cnt_next   = 3'd0;
            end else if (cnt_reg == len_reg + 3'd1) begin
               state_next = IDLE;
               cnt_next   = 3'd0;
               if (client_reg == CLIENT_IC) begin
                  ic_data_next  = final_word;
                  ic_valid_next = 1'b1;
               end else begin
                  ls_rdata_next = final_word;
                  ls_valid_next = 1'b1;
               end
            end else begin
               buf_next = capture_word;
               cnt_next = cnt_reg + 3'd1;
               if (cnt_reg < len_reg) begin
                  mem_a_next = issue_addr;
               end
            end
         end
         WRITE: begin
            if (cnt_reg == len_reg) begin
               state_next    = IDLE;
               cnt_next      = 3'd0;
               ls_valid_next = 1'b1;
            end else if (!stall_write) begin
               mem_a_next    = issue_addr;
               mem_dout_next = wbyte[cnt_reg[1:0]];
               mem_wr_next   = 1'b1;
               cnt_next      = cnt_reg + 3'd1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register: reset wins, otherwise everything freezes while rdy is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= 3'd0;
         len_reg      <= 3'd0;
         base_reg     <= 32'd0;
         wdata_reg    <= 32'd0;
         client_reg   <= CLIENT_IC;
         last_reg     <= CLIENT_IC;
         buf_reg      <= 32'd0;
         mem_a_reg    <= 32'd0;
         mem_dout_reg <= 8'd0;
         mem_wr_reg   <= 1'b0;
         ic_valid_reg <= 1'b0;
         ls_valid_reg <= 1'b0;
         ic_data_reg  <= 32'd0;
         ls_rdata_reg <= 32'd0;
      end else if (bus.rdy) begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         len_reg      <= len_next;
         base_reg     <= base_next;
         wdata_reg    <= wdata_next;
         client_reg   <= client_next;
         last_reg     <= last_next;
         buf_reg      <= buf_next;
         mem_a_reg    <= mem_a_next;
         mem_dout_reg <= mem_dout_next;
         mem_wr_reg   <= mem_wr_next;
         ic_valid_reg <= ic_valid_next;
         ls_valid_reg <= ls_valid_next;
         ic_data_reg  <= ic_data_next;
         ls_rdata_reg <= ls_rdata_next;
      end
   end

   assign bus.mem_a    = mem_a_reg;
   assign bus.mem_dout = mem_dout_reg;
   assign bus.mem_wr   = mem_wr_reg && bus.rdy;   // a paused system must not write
   assign bus.ic_valid = ic_valid_reg;
   assign bus.ic_data  = ic_data_reg;
   assign bus.ls_valid = ls_valid_reg;
   assign bus.ls_rdata = ls_rdata_reg;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl. Expected read data and write
// bytes are queued when a request is driven and consumed when the controller
// produces valid pulses or RAM writes.
module tb_mem_ctrl;
   logic clk = 1'b0;
   logic rst;

   mem_ctrl_if bus();

   mem_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks_total  = 0;
   int checks_passed = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_total++;
      if (got === exp) checks_passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Memory image: bit 8 flags a written byte; unwritten bytes use def_byte.
   bit [8:0] ram    [65536];
   bit [8:0] shadow [65536];

   function automatic logic [7:0] def_byte(input logic [31:0] a);
      case (a)
         32'h0000_0100: return 8'h13;
         32'h0000_0101: return 8'h05;
         32'h0000_0102: return 8'h10;
         32'h0000_0103: return 8'h00;
         32'h0000_0203: return 8'hFF;
         default:       return a[7:0] ^ a[15:8] ^ 8'h5A;
      endcase
   endfunction

   function automatic logic [7:0] shadow_rd(input logic [31:0] a);
      return shadow[a[15:0]][8] ? shadow[a[15:0]][7:0] : def_byte(a);
   endfunction

   function automatic logic [31:0] shadow_word(input logic [31:0] a);
      return {shadow_rd(a + 32'd3), shadow_rd(a + 32'd2), shadow_rd(a + 32'd1), shadow_rd(a)};
   endfunction

   // RAM with one cycle read latency, paused together with the system by rdy.
   always @(posedge clk) begin
      if (bus.rdy) begin
         bus.mem_din <= ram[bus.mem_a[15:0]][8] ? ram[bus.mem_a[15:0]][7:0] : def_byte(bus.mem_a);
         if (bus.mem_wr) ram[bus.mem_a[15:0]] <= {1'b1, bus.mem_dout};
      end
   end

   typedef struct packed { logic [31:0] addr; logic [7:0] data; } wr_t;
   typedef struct packed { logic chk; logic [31:0] data; } rsp_t;

   logic [31:0] ic_q [$];
   rsp_t        ls_q [$];
   wr_t         wr_q [$];

   logic full_prev = 1'b0;
   logic ic_prev   = 1'b0;
   logic ls_prev   = 1'b0;

   always @(posedge clk) full_prev <= bus.io_buffer_full;

   // Output monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.ic_valid) begin
            check("ic_excl", 32'(bus.ls_valid), 32'd0);
            check("ic_pulse", 32'(ic_prev), 32'd0);
            if (ic_q.size() == 0) check("ic_unexpected", 32'(bus.ic_valid), 32'd0);
            else begin
               check("ic_data", bus.ic_data, ic_q[0]);
               ic_q.delete(0);
            end
         end
         if (bus.ls_valid) begin
            check("ls_pulse", 32'(ls_prev), 32'd0);
            if (ls_q.size() == 0) check("ls_unexpected", 32'(bus.ls_valid), 32'd0);
            else begin
               if (ls_q[0].chk) check("ls_rdata", bus.ls_rdata, ls_q[0].data);
               ls_q.delete(0);
            end
         end
         if (bus.mem_wr) begin
            if (bus.mem_a[17:16] == 2'b11) check("io_stall", 32'(full_prev), 32'd0);
            if (wr_q.size() == 0) check("wr_unexpected", 32'(bus.mem_wr), 32'd0);
            else begin
               check("wr_addr", bus.mem_a, wr_q[0].addr);
               check("wr_data", 32'(bus.mem_dout), 32'(wr_q[0].data));
               wr_q.delete(0);
            end
         end
      end
      ic_prev <= bus.ic_valid;
      ls_prev <= bus.ls_valid;
   end

   // One request from idle; measures edges from accept (k=1) to valid.
   task automatic do_req(input bit is_ic, input bit wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int stall, input int pause_at, input int pause_len);
      int n;
      int k;
      int exp_lat;
      bit got;
      logic [31:0] exp_d;
      n = is_ic ? 4 : (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      exp_d = 32'd0;
      for (int i = 0; i < n; i++) begin
         logic [31:0] a;
         a = addr + 32'(i);
         if (wr) begin
            wr_q.push_back('{addr: a, data: wdata[8*i +: 8]});
            shadow[a[15:0]] = {1'b1, wdata[8*i +: 8]};
         end else begin
            exp_d[8*i +: 8] = shadow_rd(a);
         end
      end
      if (wr) ls_q.push_back('{chk: 1'b0, data: 32'd0});
      else if (is_ic) ic_q.push_back(exp_d);
      else ls_q.push_back('{chk: 1'b1, data: exp_d});
      exp_lat = wr ? (n + 1 + stall) : (n + 2 + pause_len);

      if (stall > 0) bus.io_buffer_full = 1'b1;
      if (is_ic) begin
         bus.ic_ena  = 1'b1;
         bus.ic_addr = addr;
      end else begin
         bus.ls_ena   = 1'b1;
         bus.ls_wr    = wr;
         bus.ls_size  = size;
         bus.ls_addr  = addr;
         bus.ls_wdata = wdata;
      end
      got = 1'b0;
      k   = 0;
      while (!got && k < 60) begin
         @(posedge clk);
         #1;
         k++;
         if (pause_at > 0 && k == pause_at) bus.rdy = 1'b0;
         if (pause_at > 0 && k == pause_at + pause_len) bus.rdy = 1'b1;
         if (stall > 0 && k == stall) bus.io_buffer_full = 1'b0;
         if (!wr && pause_at <= 0 && k <= n) check("rd_addr", bus.mem_a, addr + 32'(k - 1));
         got = is_ic ? bus.ic_valid : bus.ls_valid;
      end
      check(is_ic ? "ic_latency" : "ls_latency", got ? 32'(k) : 32'hFFFF_FFFF, 32'(exp_lat));
      $display("txn %s %s addr=0x%08h bytes=%0d latency=%0d", is_ic ? "ic" : "ls",
               wr ? "store" : "load", addr, n, k);
      bus.ic_ena = 1'b0;
      bus.ls_ena = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input bit is_ic, output int k);
      bit got;
      got = 1'b0;
      k   = 0;
      while (!got && k < 60) begin
         @(posedge clk);
         #1;
         k++;
         got = is_ic ? bus.ic_valid : bus.ls_valid;
      end
      if (!got) k = -1;
   endtask

   task automatic check_reset_outputs(input string phase);
      check({phase, "_mem_a"},    bus.mem_a, 32'd0);
      check({phase, "_mem_dout"}, 32'(bus.mem_dout), 32'd0);
      check({phase, "_mem_wr"},   32'(bus.mem_wr), 32'd0);
      check({phase, "_ic_valid"}, 32'(bus.ic_valid), 32'd0);
      check({phase, "_ls_valid"}, 32'(bus.ls_valid), 32'd0);
      check({phase, "_ic_data"},  bus.ic_data, 32'd0);
      check({phase, "_ls_rdata"}, bus.ls_rdata, 32'd0);
   endtask

   initial begin
      int k;
      rst                = 1'b1;
      bus.rdy            = 1'b1;
      bus.ic_ena         = 1'b0;
      bus.ic_addr        = 32'd0;
      bus.ls_ena         = 1'b0;
      bus.ls_wr          = 1'b0;
      bus.ls_size        = 2'd0;
      bus.ls_addr        = 32'd0;
      bus.ls_wdata       = 32'd0;
      bus.io_buffer_full = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Tie from reset: LSB first, icache after one idle cycle, next tie to LSB.
      ls_q.push_back('{chk: 1'b1, data: {24'd0, shadow_rd(32'h203)}});
      bus.ls_ena  = 1'b1;
      bus.ls_wr   = 1'b0;
      bus.ls_size = 2'd0;
      bus.ls_addr = 32'h203;
      bus.ic_ena  = 1'b1;
      bus.ic_addr = 32'h100;
      wait_valid(1'b0, k);
      check("tie1_ls_first", 32'(k), 32'd3);
      $display("txn tie ls load addr=0x00000203 latency=%0d", k);
      bus.ls_ena = 1'b0;
      ic_q.push_back(shadow_word(32'h100));
      wait_valid(1'b1, k);
      check("tie1_ic_next", 32'(k), 32'd7);
      $display("txn tie ic load addr=0x00000100 latency=%0d", k);
      ls_q.push_back('{chk: 1'b1, data: {24'd0, shadow_rd(32'h203)}});
      bus.ls_ena = 1'b1;
      wait_valid(1'b0, k);
      check("tie2_ls_first", 32'(k), 32'd4);
      $display("txn tie ls load addr=0x00000203 latency=%0d", k);
      bus.ls_ena = 1'b0;
      ic_q.push_back(shadow_word(32'h100));
      wait_valid(1'b1, k);
      check("tie2_ic_next", 32'(k), 32'd7);
      $display("txn tie ic load addr=0x00000100 latency=%0d", k);
      bus.ic_ena = 1'b0;
      @(posedge clk);
      #1;

      // Single transactions.
      do_req(1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'd0,          0, 0, 0);
      do_req(1'b0, 1'b0, 2'd0, 32'h0000_0203, 32'd0,          0, 0, 0);
      do_req(1'b0, 1'b1, 2'd1, 32'h0000_1001, 32'h0000_BEEF,  0, 0, 0);
      do_req(1'b0, 1'b0, 2'd1, 32'h0000_1001, 32'd0,          0, 0, 0);
      do_req(1'b0, 1'b1, 2'd0, 32'h0003_0000, 32'h0000_0041,  3, 0, 0);
      do_req(1'b0, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'd0,          0, 0, 0);
      do_req(1'b0, 1'b1, 2'd2, 32'hFFFF_FFFF, 32'hCAFE_F00D,  0, 0, 0);
      do_req(1'b0, 1'b0, 2'd3, 32'hFFFF_FFFF, 32'd0,          0, 0, 0);
      do_req(1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'd0,          0, 3, 2);

      // Icache abort: request dropped mid-read must never produce ic_valid.
      bus.ic_ena  = 1'b1;
      bus.ic_addr = 32'h0000_0200;
      repeat (2) begin @(posedge clk); #1; end
      bus.ic_ena = 1'b0;
      repeat (8) begin @(posedge clk); #1; end
      check("abort_ic_valid", 32'(bus.ic_valid), 32'd0);
      $display("txn ic abort addr=0x00000200");

      // Reset in the middle of a word read.
      bus.ic_ena  = 1'b1;
      bus.ic_addr = 32'h0000_0100;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outputs("midrst");
      rst        = 1'b0;
      bus.ic_ena = 1'b0;
      repeat (8) begin @(posedge clk); #1; end
      $display("txn ic reset-abort addr=0x00000100");

      do_req(1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'd0, 0, 0, 0);
      do_req(1'b0, 1'b0, 2'd2, 32'h0000_1000, 32'd0, 0, 0, 0);

      check("ic_q_drained", 32'(ic_q.size()), 32'd0);
      check("ls_q_drained", 32'(ls_q.size()), 32'd0);
      check("wr_q_drained", 32'(wr_q.size()), 32'd0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end
endmodule
